// File: rtl/ext_mem_wait.sv
// External data memory with byte-enable writes, a ready pulse and a fixed wait-state latency.
// Optional EXT_MEM_WAIT_RANDOM_STALL_EN adds 0..3 LFSR-driven extra wait cycles per request.
module ext_mem_wait #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mem_req_i,
  input  logic                    write_enable_i,
  input  logic [DATA_WIDTH/8-1:0] byte_enable_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  output logic [DATA_WIDTH-1:0]   read_data_o,
  output logic                    ready_o,
  output logic                    busy_o
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q;
  logic [BYTES-1:0]      be_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  accept;
  logic                  commit;
  logic [IDX_W-1:0]      req_idx;
  logic [CNT_W-1:0]      lat_total;
  logic                  c_we;
  logic [BYTES-1:0]      c_be;
  logic [IDX_W-1:0]      c_idx;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  unused_addr;

  assign accept      = (state_q == S_IDLE) && mem_req_i;
  assign req_idx     = addr_i[OFF_W +: IDX_W];
  assign unused_addr = ^addr_i;

`ifdef EXT_MEM_WAIT_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     lfsr_q <= 16'hACE1;
    else if (accept) lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
  end

  // The pre-advance LFSR value sets the stall of the request being accepted.
  assign lat_total = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign lat_total = CNT_W'(LATENCY);
`endif

  // With a one-cycle latency the commit happens on the acceptance edge, so
  // the request fields come straight from the inputs rather than the latches.
  assign c_we    = (state_q == S_IDLE) ? write_enable_i : we_q;
  assign c_be    = (state_q == S_IDLE) ? byte_enable_i  : be_q;
  assign c_idx   = (state_q == S_IDLE) ? req_idx        : idx_q;
  assign c_wdata = (state_q == S_IDLE) ? write_data_i   : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = lat_total - CNT_W'(1);
          if (lat_total > CNT_W'(1)) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_DONE;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= commit;
      if (commit && !c_we) rdata_q <= mem[c_idx];
      if (accept) begin
        we_q    <= write_enable_i;
        be_q    <= byte_enable_i;
        idx_q   <= req_idx;
        wdata_q <= write_data_i;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < BYTES; k++) begin
      if (commit && c_we && c_be[k]) mem[c_idx][k*8 +: 8] <= c_wdata[k*8 +: 8];
    end
  end

  assign read_data_o = rdata_q;
  assign ready_o     = ready_q;
  assign busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_ext_mem_wait.sv
// Self-checking bench for ext_mem_wait: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural memory model.
module tb_ext_mem_wait;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4096;
`ifdef EXT_MEM_WAIT_RANDOM_STALL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk;
  logic          rst_ni;
  logic          mem_req_i;
  logic          write_enable_i;
  logic [3:0]    byte_enable_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] write_data_i;
  logic [DW-1:0] read_data_o;
  logic          ready_o;
  logic          busy_o;

  ext_mem_wait #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .mem_req_i     (mem_req_i),
    .write_enable_i(write_enable_i),
    .byte_enable_i (byte_enable_i),
    .addr_i        (addr_i),
    .write_data_i  (write_data_i),
    .read_data_o   (read_data_o),
    .ready_o       (ready_o),
    .busy_o        (busy_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state and scoreboard
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] model_rd;
  logic [15:0]   model_lfsr;
  logic [DW-1:0] exp_q [$];
  int            n_checks;
  int            n_fail;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12];

  function automatic int word_of(input logic [AW-1:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic nb;
    nb = l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11];
    return {nb, l[15:1]};
  endfunction

  function automatic int exp_latency();
`ifdef EXT_MEM_WAIT_RANDOM_STALL_EN
    return LAT + int'(model_lfsr[1:0]);
`else
    return LAT;
`endif
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_ni         = 1'b0;
    mem_req_i      = 1'b0;
    write_enable_i = 1'b0;
    byte_enable_i  = '0;
    addr_i         = '0;
    write_data_i   = '0;
    repeat (3) @(negedge clk);
    rst_ni     = 1'b1;
    model_rd   = '0;
    model_lfsr = 16'hACE1;
    exp_q.delete();
  endtask

  // Driver: one complete transaction, checking busy/ready every cycle.
  task automatic do_txn(input bit we, input logic [3:0] be, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input bit scramble, output logic [DW-1:0] rd);
    int            lat;
    int            w;
    logic [DW-1:0] tmp;
    logic [DW-1:0] exp;
    @(negedge clk);
    chk("idle_busy", {31'b0, busy_o}, 32'd0);
    chk("idle_ready", {31'b0, ready_o}, 32'd0);
    mem_req_i      = 1'b1;
    write_enable_i = we;
    byte_enable_i  = be;
    addr_i         = addr;
    write_data_i   = wd;
    lat = exp_latency();
    w   = word_of(addr);
    if (!we) exp_q.push_back(model_mem.exists(w) ? model_mem[w] : 'x);
    @(posedge clk);
    model_lfsr = lfsr_step(model_lfsr);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (scramble && c == 1) begin
        addr_i         = addr + 32'd4;
        write_enable_i = ~we;
        byte_enable_i  = 4'hF;
        write_data_i   = $urandom;
      end
      chk("busy_outstanding", {31'b0, busy_o}, 32'd1);
      chk("ready_pulse", {31'b0, ready_o}, {31'b0, c == lat});
    end
    rd        = read_data_o;
    mem_req_i = 1'b0;
    if (!we) begin
      exp = exp_q.pop_front();
      chk("read_data", rd, exp);
      model_rd = exp;
    end else begin
      chk("read_data_hold", rd, model_rd);
      tmp = model_mem.exists(w) ? model_mem[w] : 'x;
      for (int k = 0; k < 4; k++) if (be[k]) tmp[k*8 +: 8] = wd[k*8 +: 8];
      model_mem[w] = tmp;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    n_checks = 0;
    n_fail   = 0;
    do_reset();
    @(negedge clk);
    chk("reset_ready", {31'b0, ready_o}, 32'd0);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_rdata", read_data_o, 32'd0);

    // Directed table: exp is read_data_o in each ready cycle.
    vecs[0]  = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 4'hF, 32'h20,   32'h11223344, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 4'h5, 32'h20,   32'hAABBCCDD, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 4'hF, 32'h20,   32'h0,        32'h11BB33DD};
    vecs[5]  = '{1'b1, 4'hF, 32'h4000, 32'hCAFEF00D, 32'h11BB33DD};
    vecs[6]  = '{1'b0, 4'h0, 32'h0000, 32'h0,        32'hCAFEF00D};
    vecs[7]  = '{1'b0, 4'h0, 32'h0003, 32'h0,        32'hCAFEF00D};
    vecs[8]  = '{1'b1, 4'hF, 32'h30,   32'h00000005, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 4'h0, 32'h30,   32'hFFFFFFFF, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 4'hF, 32'h30,   32'h0,        32'h00000005};
    vecs[11] = '{1'b1, 4'hF, 32'h34,   32'h00000099, 32'h00000005};
    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, 1'b0, rd);
      chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // Inputs disturbed mid-transaction must not leak into the access.
    do_txn(1'b0, 4'h0, 32'h30, 32'h0, 1'b1, rd);
    chk("latched_read", rd, 32'h5);
    do_txn(1'b1, 4'hF, 32'h50, 32'h0BADF00D, 1'b1, rd);
    chk("hold_after_write", rd, 32'h5);
    do_txn(1'b0, 4'h0, 32'h34, 32'h0, 1'b0, rd);
    chk("scrambled_write_ignored", rd, 32'h99);

    // Reset during WAIT aborts the write.
    do_txn(1'b1, 4'hF, 32'h40, 32'h0, 1'b0, rd);
    if (exp_latency() >= 2) begin
      @(negedge clk);
      mem_req_i = 1'b1; write_enable_i = 1'b1; byte_enable_i = 4'hF;
      addr_i = 32'h40; write_data_i = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b0;
      mem_req_i = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy_o}, 32'd0);
      chk("abort_rdata", read_data_o, 32'd0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("abort_no_ready", {31'b0, ready_o}, 32'd0);
      end
      rst_ni     = 1'b1;
      model_rd   = '0;
      model_lfsr = 16'hACE1;
      exp_q.delete();
    end else begin
      do_reset();
    end
    do_txn(1'b0, 4'h0, 32'h40, 32'h0, 1'b0, rd);
    chk("abort_read_back", rd, 32'h0);

    // Randomized traffic over 16 words, aliased through the wrap region.
    for (int i = 0; i < 16; i++) do_txn(1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0, rd);
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      a = 32'(($urandom_range(0, 15) + DEPTH * $urandom_range(0, 3)) * 4 + $urandom_range(0, 3));
      do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
             1'($urandom_range(0, 1)), rd);
    end

    // Back-to-back reads straight after reset.
    do_reset();
    for (int i = 0; i < 8; i++) do_txn(1'b0, 4'h0, 32'(i * 4), 32'h0, 1'b0, rd);
    @(negedge clk);
    chk("final_idle", {31'b0, busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
